// File: rtl/xcel_mem_resp.sv
// Accelerator-side memory responder: read and write AXI-style bursts served
// from a dual-port, read-first RAM. The two channels run independently.
module xcel_mem_resp #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  xcel_read_request_valid,
  output logic                  xcel_read_request_ready,
  input  logic [AXI_AWIDTH-1:0] xcel_read_addr,
  input  logic [31:0]           xcel_read_len,
  input  logic [2:0]            xcel_read_size,
  input  logic [1:0]            xcel_read_burst,
  output logic [AXI_DWIDTH-1:0] xcel_read_data,
  output logic                  xcel_read_data_valid,
  input  logic                  xcel_read_data_ready,
  input  logic                  xcel_write_request_valid,
  output logic                  xcel_write_request_ready,
  input  logic [AXI_AWIDTH-1:0] xcel_write_addr,
  input  logic [31:0]           xcel_write_len,
  input  logic [2:0]            xcel_write_size,
  input  logic [1:0]            xcel_write_burst,
  input  logic [AXI_DWIDTH-1:0] xcel_write_data,
  input  logic                  xcel_write_data_valid,
  output logic                  xcel_write_data_ready,
  output logic                  rd_busy,
  output logic                  wr_busy
);
  localparam int DEPTH = 1 << MEM_AWIDTH;

  typedef enum logic {R_IDLE, R_BURST} rd_state_t;
  typedef enum logic {W_IDLE, W_DATA} wr_state_t;

  logic [AXI_DWIDTH-1:0] ram_q [DEPTH];
  logic [AXI_DWIDTH-1:0] ram_rdata_q;

  rd_state_t             rd_state_q, rd_state_d;
  logic [MEM_AWIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  rd_fixed_q, rd_fixed_d;
  logic                  rd_issue_pend_q, rd_issue_pend_d;
  logic [31:0]           rd_issue_left_q, rd_issue_left_d;
  logic [31:0]           rd_beats_left_q, rd_beats_left_d;
  logic                  ram_vld_q, ram_vld_d;
  logic [AXI_DWIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_accept, rd_advance, rd_issue, rd_fire;

  wr_state_t             wr_state_q, wr_state_d;
  logic [MEM_AWIDTH-1:0] wr_idx_q, wr_idx_d;
  logic                  wr_fixed_q, wr_fixed_d;
  logic [31:0]           wr_left_q, wr_left_d;
  logic                  wr_accept, wr_fire;

  logic unused_bits;
  assign unused_bits = ^{xcel_read_size, xcel_write_size, xcel_read_addr, xcel_write_addr};

  // Two-stage read pipeline (RAM register, output register) that advances in
  // lockstep, so a stalled beat freezes both stages and nothing is lost.
  always_comb begin
    rd_accept  = (rd_state_q == R_IDLE) && xcel_read_request_valid;
    rd_advance = !rd_valid_q || xcel_read_data_ready;
    rd_issue   = rd_advance && rd_issue_pend_q;
    rd_fire    = rd_valid_q && xcel_read_data_ready;

    rd_state_d      = rd_state_q;
    rd_idx_d        = rd_idx_q;
    rd_fixed_d      = rd_fixed_q;
    rd_issue_pend_d = rd_issue_pend_q;
    rd_issue_left_d = rd_issue_left_q;
    rd_beats_left_d = rd_beats_left_q;
    ram_vld_d       = ram_vld_q;
    rd_data_d       = rd_data_q;
    rd_valid_d      = rd_valid_q;

    if (rd_accept) begin
      rd_state_d      = R_BURST;
      rd_idx_d        = xcel_read_addr[MEM_AWIDTH+1:2];
      rd_fixed_d      = (xcel_read_burst == 2'b00);
      rd_issue_pend_d = 1'b1;
      rd_issue_left_d = xcel_read_len;
      rd_beats_left_d = xcel_read_len;
    end
    if (rd_issue) begin
      if (!rd_fixed_q) rd_idx_d = rd_idx_q + MEM_AWIDTH'(1);
      if (rd_issue_left_q == 32'd0) rd_issue_pend_d = 1'b0;
      else                          rd_issue_left_d = rd_issue_left_q - 32'd1;
    end
    if (rd_advance) begin
      ram_vld_d  = rd_issue;
      rd_valid_d = ram_vld_q;
      if (ram_vld_q) rd_data_d = ram_rdata_q;
    end
    if (rd_fire) begin
      if (rd_beats_left_q == 32'd0) rd_state_d = R_IDLE;
      else                          rd_beats_left_d = rd_beats_left_q - 32'd1;
    end
  end

  always_comb begin
    wr_accept  = (wr_state_q == W_IDLE) && xcel_write_request_valid;
    wr_fire    = (wr_state_q == W_DATA) && xcel_write_data_valid;
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_fixed_d = wr_fixed_q;
    wr_left_d  = wr_left_q;

    if (wr_accept) begin
      wr_state_d = W_DATA;
      wr_idx_d   = xcel_write_addr[MEM_AWIDTH+1:2];
      wr_fixed_d = (xcel_write_burst == 2'b00);
      wr_left_d  = xcel_write_len;
    end
    if (wr_fire) begin
      if (!wr_fixed_q) wr_idx_d = wr_idx_q + MEM_AWIDTH'(1);
      if (wr_left_q == 32'd0) wr_state_d = W_IDLE;
      else                    wr_left_d  = wr_left_q - 32'd1;
    end
  end

  // Nonblocking read and write of the same word gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) ram_q[wr_idx_q] <= xcel_write_data;
    if (rd_issue) ram_rdata_q <= ram_q[rd_idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q      <= R_IDLE;
      rd_idx_q        <= '0;
      rd_fixed_q      <= 1'b0;
      rd_issue_pend_q <= 1'b0;
      rd_issue_left_q <= '0;
      rd_beats_left_q <= '0;
      ram_vld_q       <= 1'b0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      wr_state_q      <= W_IDLE;
      wr_idx_q        <= '0;
      wr_fixed_q      <= 1'b0;
      wr_left_q       <= '0;
    end else begin
      rd_state_q      <= rd_state_d;
      rd_idx_q        <= rd_idx_d;
      rd_fixed_q      <= rd_fixed_d;
      rd_issue_pend_q <= rd_issue_pend_d;
      rd_issue_left_q <= rd_issue_left_d;
      rd_beats_left_q <= rd_beats_left_d;
      ram_vld_q       <= ram_vld_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      wr_state_q      <= wr_state_d;
      wr_idx_q        <= wr_idx_d;
      wr_fixed_q      <= wr_fixed_d;
      wr_left_q       <= wr_left_d;
    end
  end

  assign xcel_read_request_ready  = (rd_state_q == R_IDLE);
  assign xcel_read_data           = rd_data_q;
  assign xcel_read_data_valid     = rd_valid_q;
  assign xcel_write_request_ready = (wr_state_q == W_IDLE);
  assign xcel_write_data_ready    = (wr_state_q == W_DATA);
  assign rd_busy                  = (rd_state_q != R_IDLE) || rd_valid_q;
  assign wr_busy                  = (wr_state_q != W_IDLE);
endmodule

// File: tb/tb_xcel_mem_resp.sv
// Bench for xcel_mem_resp: random bursts checked against an array model of
// the RAM, plus directed latency, stall, wrap, collision and reset scenarios.
module tb_xcel_mem_resp;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [31:0] rd_addr = '0, rd_len = '0;
  logic [2:0]  rd_size = 3'd2;
  logic [1:0]  rd_burst = 2'b01;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready = 1'b0;
  logic        wr_req_valid = 1'b0, wr_req_ready;
  logic [31:0] wr_addr = '0, wr_len = '0;
  logic [2:0]  wr_size = 3'd2;
  logic [1:0]  wr_burst = 2'b01;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic        rd_busy, wr_busy;

  int checks = 0, failures = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wdata_q[$];
  logic [31:0] rd_got[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  xcel_mem_resp #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .MEM_AWIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .xcel_read_request_valid(rd_req_valid), .xcel_read_request_ready(rd_req_ready),
    .xcel_read_addr(rd_addr), .xcel_read_len(rd_len), .xcel_read_size(rd_size),
    .xcel_read_burst(rd_burst), .xcel_read_data(rd_data),
    .xcel_read_data_valid(rd_valid), .xcel_read_data_ready(rd_ready),
    .xcel_write_request_valid(wr_req_valid), .xcel_write_request_ready(wr_req_ready),
    .xcel_write_addr(wr_addr), .xcel_write_len(wr_len), .xcel_write_size(wr_size),
    .xcel_write_burst(wr_burst), .xcel_write_data(wr_data),
    .xcel_write_data_valid(wr_valid), .xcel_write_data_ready(wr_ready),
    .rd_busy(rd_busy), .wr_busy(wr_busy)
  );

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic void model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int idx = widx(addr);
    for (int b = 0; b <= len; b++) begin
      model[idx] = wdata_q[b];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
  endfunction

  function automatic void model_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int idx = widx(addr);
    exp_q.delete();
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back(model[idx]);
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
  endfunction

  // Write burst driver; data beats come from wdata_q, gap_pct inserts idle cycles.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int gap_pct, output bit timeout);
    int cyc = 0;
    int beat = 0;
    bit fire;
    @(negedge clk);
    wr_req_valid = 1'b1; wr_addr = addr; wr_len = 32'(len); wr_burst = burst;
    wr_size = 3'($urandom_range(7));
    while (!wr_req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    wr_req_valid = 1'b0;
    while (beat <= len && cyc < 20 * (len + 1) + 200) begin
      if (int'($urandom_range(99)) < gap_pct) wr_valid = 1'b0;
      else begin wr_valid = 1'b1; wr_data = wdata_q[beat]; end
      fire = wr_valid && wr_ready;
      @(negedge clk);
      cyc++;
      if (fire) beat++;
    end
    wr_valid = 1'b0;
    timeout = (beat <= len);
  endtask

  // Read burst driver; mode 0 = ready held high, 1 = ready 1,0,0 repeating, 2 = random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input int mode, output int latency, output int cycles,
                         output int stall_err, output bit timeout);
    int cyc = 0;
    int k = 0;
    bit held = 1'b0;
    logic [31:0] held_data = '0;
    latency = -1; stall_err = 0;
    rd_got.delete();
    @(negedge clk);
    rd_req_valid = 1'b1; rd_addr = addr; rd_len = 32'(len); rd_burst = burst;
    rd_size = 3'($urandom_range(7));
    while (!rd_req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    rd_req_valid = 1'b0;
    while (rd_got.size() <= len && k < 20 * (len + 1) + 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 3 == 0);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      if (held && (!rd_valid || rd_data !== held_data)) stall_err++;
      if (rd_valid) begin
        if (latency < 0) latency = k;
        held = !rd_ready;
        held_data = rd_data;
        if (rd_ready) rd_got.push_back(rd_data);
      end
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    cycles = k;
    timeout = (rd_got.size() <= len);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 7;
    if (rd_req_ready !== 1'b1) begin failures++; $display("FAIL reset_rd_req_ready: got %b expected 1", rd_req_ready); end
    if (wr_req_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_req_ready: got %b expected 1", wr_req_ready); end
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_data_ready: got %b expected 0", wr_ready); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    if (rd_busy !== 1'b0) begin failures++; $display("FAIL reset_rd_busy: got %b expected 0", rd_busy); end
    if (wr_busy !== 1'b0) begin failures++; $display("FAIL reset_wr_busy: got %b expected 0", wr_busy); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_fill();
    bit to;
    wdata_q.delete();
    for (int i = 0; i < DEPTH; i++) wdata_q.push_back($urandom);
    do_write(32'h0, DEPTH - 1, 2'b01, 20, to);
    model_write(32'h0, DEPTH - 1, 2'b01);
    checks++;
    if (to) begin failures++; $display("FAIL fill_timeout: got timeout expected completion"); end
    $display("fill: wrote %0d words", DEPTH);
  endtask

  task automatic test_write_basic();
    bit to;
    wdata_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(32'h100, 3, 2'b01, 0, to);
    model_write(32'h100, 3, 2'b01);
    checks += 3;
    if (to) begin failures++; $display("FAIL wbasic_timeout: got timeout expected completion"); end
    if (wr_req_ready !== 1'b1) begin failures++; $display("FAIL wbasic_req_ready: got %b expected 1", wr_req_ready); end
    if (wr_busy !== 1'b0) begin failures++; $display("FAIL wbasic_busy: got %b expected 0", wr_busy); end
    $display("write addr=0x100 len=3 INCR: done");
  endtask

  task automatic test_read_stream();
    int lat, cyc, serr; bit to;
    do_read(32'h100, 3, 2'b01, 0, lat, cyc, serr, to);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    checks += 5;
    if (to) begin failures++; $display("FAIL rstream_timeout: got %0d beats expected 4", rd_got.size()); end
    if (lat != 2) begin failures++; $display("FAIL rstream_latency: got %0d expected 2", lat); end
    if (cyc != 6) begin failures++; $display("FAIL rstream_back_to_back: got %0d cycles expected 6", cyc); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL rstream_valid_drop: got %b expected 0", rd_valid); end
    if (rd_busy !== 1'b0) begin failures++; $display("FAIL rstream_busy: got %b expected 0", rd_busy); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== exp_q[i]) begin
        failures++; $display("FAIL rstream_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, exp_q[i]);
      end
    end
    $display("read addr=0x100 len=3 ready=1: latency %0d, %0d beats", lat, rd_got.size());
  endtask

  task automatic test_read_stall();
    int lat, cyc, serr; bit to;
    do_read(32'h100, 3, 2'b01, 1, lat, cyc, serr, to);
    checks += 3;
    if (to || rd_got.size() != 4) begin failures++; $display("FAIL rstall_count: got %0d beats expected 4", rd_got.size()); end
    if (serr != 0) begin failures++; $display("FAIL rstall_stable: got %0d stall violations expected 0", serr); end
    if (lat != 2) begin failures++; $display("FAIL rstall_latency: got %0d expected 2", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL rstall_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, 32'hA0 + 32'(i));
      end
    end
    $display("read addr=0x100 len=3 ready 1,0,0: %0d beats", rd_got.size());
  endtask

  task automatic test_fixed_and_wrap();
    int lat, cyc, serr; bit to;
    do_read(32'h104, 2, 2'b00, 2, lat, cyc, serr, to);
    checks++;
    if (to || rd_got.size() != 3) begin failures++; $display("FAIL fixed_count: got %0d beats expected 3", rd_got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== model[12'h041]) begin
        failures++; $display("FAIL fixed_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, model[12'h041]);
      end
    end
    wdata_q = '{$urandom, $urandom};
    do_write(32'h3FFC, 1, 2'b01, 0, to);
    model_write(32'h3FFC, 1, 2'b01);
    do_read(32'hFFFF_3FFC, 1, 2'b11, 0, lat, cyc, serr, to);
    checks++;
    if (to || rd_got.size() != 2) begin failures++; $display("FAIL wrap_count: got %0d beats expected 2", rd_got.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== wdata_q[i]) begin
        failures++; $display("FAIL wrap_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, wdata_q[i]);
      end
    end
    $display("fixed read 0x104 x3 and wrap write 0x3FFC: done");
  endtask

  task automatic test_idle_data_ignored();
    int lat, cyc, serr; bit to;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
      checks++;
      if (wr_ready !== 1'b0) begin failures++; $display("FAIL idle_wr_ready: got %b expected 0", wr_ready); end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    model_read(32'h0, 2, 2'b01);
    do_read(32'h0, 2, 2'b01, 0, lat, cyc, serr, to);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== exp_q[i]) begin
        failures++; $display("FAIL idle_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, exp_q[i]);
      end
    end
    $display("write data in idle: ignored check done");
  endtask

  task automatic test_concurrent();
    int lat, cyc, serr; bit wto, rto;
    logic [31:0] old_v, new_v;
    wdata_q.delete();
    for (int i = 0; i < 8; i++) wdata_q.push_back($urandom);
    model_read(32'h40, 15, 2'b01);
    fork
      do_write(32'h800, 7, 2'b01, 30, wto);
      do_read(32'h40, 15, 2'b01, 2, lat, cyc, serr, rto);
    join
    model_write(32'h800, 7, 2'b01);
    checks += 2;
    if (wto || rto) begin failures++; $display("FAIL conc_timeout: got wr=%0d rd=%0d expected 0 0", wto, rto); end
    if (serr != 0) begin failures++; $display("FAIL conc_stable: got %0d violations expected 0", serr); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== exp_q[i]) begin
        failures++; $display("FAIL conc_rd_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, exp_q[i]);
      end
    end
    model_read(32'h800, 7, 2'b01);
    do_read(32'h800, 7, 2'b01, 0, lat, cyc, serr, rto);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== exp_q[i]) begin
        failures++; $display("FAIL conc_wr_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, exp_q[i]);
      end
    end
    // Same-cycle read issue and write to word 0xC0.
    old_v = model[12'h0C0];
    new_v = ~old_v;
    @(negedge clk);
    rd_req_valid = 1'b1; rd_addr = 32'h300; rd_len = 0; rd_burst = 2'b01; rd_ready = 1'b1;
    wr_req_valid = 1'b1; wr_addr = 32'h300; wr_len = 0; wr_burst = 2'b01;
    @(negedge clk);
    rd_req_valid = 1'b0; wr_req_valid = 1'b0; wr_valid = 1'b1; wr_data = new_v;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== old_v) begin
      failures++; $display("FAIL collision_old: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, old_v);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    model[12'h0C0] = new_v;
    do_read(32'h300, 0, 2'b01, 0, lat, cyc, serr, rto);
    checks++;
    if (rd_got.size() != 1 || rd_got[0] !== new_v) begin
      failures++; $display("FAIL collision_new: got %h expected %h", (rd_got.size() > 0) ? rd_got[0] : 32'hx, new_v);
    end
    $display("concurrent write 0x800 / read 0x40 and collision at 0x300: done");
  endtask

  task automatic test_random();
    int lat, cyc, serr; bit wto, rto;
    logic [31:0] addr; int len; logic [1:0] wb, rb;
    for (int it = 0; it < 8; it++) begin
      addr = $urandom; len = int'($urandom_range(12));
      wb = 2'($urandom_range(3)); rb = 2'($urandom_range(3));
      wdata_q.delete();
      for (int i = 0; i <= len; i++) wdata_q.push_back($urandom);
      do_write(addr, len, wb, 25, wto);
      model_write(addr, len, wb);
      model_read(addr, len, rb);
      do_read(addr, len, rb, 2, lat, cyc, serr, rto);
      checks += 2;
      if (wto || rto || rd_got.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count: got %0d beats expected %0d", it, rd_got.size(), exp_q.size());
      end
      if (serr != 0) begin failures++; $display("FAIL rand%0d_stable: got %0d violations expected 0", it, serr); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= rd_got.size() || rd_got[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_beat%0d: got %h expected %h", it, i, (i < rd_got.size()) ? rd_got[i] : 32'hx, exp_q[i]);
        end
      end
      $display("random %0d: addr=%h len=%0d wburst=%0d rburst=%0d", it, addr, len, wb, rb);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, cyc, serr, fired, guard; bit rto;
    wdata_q = '{$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wr_req_valid = 1'b1; wr_addr = 32'h200; wr_len = 3; wr_burst = 2'b01;
    @(negedge clk);
    wr_req_valid = 1'b0;
    fired = 0; guard = 0;
    while (fired < 2 && guard < 20) begin
      wr_valid = 1'b1; wr_data = wdata_q[fired];
      if (wr_ready) fired++;
      @(negedge clk);
      guard++;
    end
    rst = 1'b1; wr_data = wdata_q[2];
    @(negedge clk);
    rst = 1'b0; wr_data = wdata_q[3];
    @(negedge clk);
    wr_valid = 1'b0;
    checks += 4;
    if (fired != 2) begin failures++; $display("FAIL rstmid_beats: got %0d accepted expected 2", fired); end
    if (wr_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", wr_busy); end
    if (wr_req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_req_ready: got %b expected 1", wr_req_ready); end
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL rstmid_data_ready: got %b expected 0", wr_ready); end
    model[12'h080] = wdata_q[0];
    model[12'h081] = wdata_q[1];
    model_read(32'h200, 3, 2'b01);
    do_read(32'h200, 3, 2'b01, 0, lat, cyc, serr, rto);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= rd_got.size() || rd_got[i] !== exp_q[i]) begin
        failures++; $display("FAIL rstmid_beat%0d: got %h expected %h", i, (i < rd_got.size()) ? rd_got[i] : 32'hx, exp_q[i]);
      end
    end
    $display("reset after 2 of 4 write beats: done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_basic();
    test_read_stream();
    test_read_stall();
    test_fixed_and_wrap();
    test_idle_data_ignored();
    test_concurrent();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xcel_mem_resp.md
XCEL_MEM_RESP -- requirements
Module: xcel_mem_resp

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 32: byte-address width of the request channels.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32: data beat width; only 32 is supported.
REQ-003 SHALL have parameter MEM_AWIDTH, default 12: log2 of backing-RAM depth in AXI_DWIDTH words.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have read request ports: xcel_read_request_valid input 1; xcel_read_request_ready output 1; xcel_read_addr input AXI_AWIDTH (byte address); xcel_read_len input 32 (beats minus 1); xcel_read_size input 3; xcel_read_burst input 2.
REQ-006 SHALL have read data ports: xcel_read_data output AXI_DWIDTH; xcel_read_data_valid output 1; xcel_read_data_ready input 1.
REQ-007 SHALL have write request ports: xcel_write_request_valid input 1; xcel_write_request_ready output 1; xcel_write_addr input AXI_AWIDTH; xcel_write_len input 32; xcel_write_size input 3; xcel_write_burst input 2.
REQ-008 SHALL have write data ports: xcel_write_data input AXI_DWIDTH; xcel_write_data_valid input 1; xcel_write_data_ready output 1.
REQ-009 SHALL have status outputs: rd_busy output 1 (read FSM not idle); wr_busy output 1 (write FSM not idle).

Function
REQ-010 SHALL serve bursts from a dual-port RAM of 2^MEM_AWIDTH words: one read port, one write port, synchronous 1-cycle read.
REQ-011 SHALL compute word index = addr[MEM_AWIDTH+1:2]; addr[1:0] and addr bits above MEM_AWIDTH+1 are ignored, so the index wraps modulo depth.
REQ-012 SHALL transfer len+1 beats per burst; len=0 is a single beat.
REQ-013 SHALL increment the word index by 1 per beat for burst 2'b01 (INCR) and 2'b10/2'b11, and hold it constant for burst 2'b00 (FIXED).
REQ-014 SHALL ignore xcel_*_size; every beat is a full AXI_DWIDTH word.
REQ-015 SHALL implement the read FSM R_IDLE -> R_BURST on request valid&ready, and R_BURST -> R_IDLE when the last beat completes data valid&ready.
REQ-016 SHALL drive xcel_read_request_ready = 1 only in R_IDLE.
REQ-017 SHALL assert xcel_read_data_valid for the first beat exactly 2 cycles after the request handshake edge: RAM read issued on the cycle after accept, data registered one cycle later.
REQ-018 SHALL stream beats back-to-back, one per cycle, while xcel_read_data_ready=1.
REQ-019 SHALL keep xcel_read_data and xcel_read_data_valid stable while valid=1 and ready=0, with no beat lost or duplicated; RAM read enable = !valid || ready.
REQ-020 SHALL deassert xcel_read_data_valid in the cycle after the last beat handshake, unless a new burst has already produced data.
REQ-021 SHALL implement the write FSM W_IDLE -> W_DATA on request handshake, and W_DATA -> W_IDLE after the (len+1)-th data handshake.
REQ-022 SHALL drive xcel_write_request_ready = 1 only in W_IDLE, and xcel_write_data_ready = 1 only in W_DATA.
REQ-023 SHALL write RAM[index] <= xcel_write_data on each write data valid&ready cycle, then advance index per REQ-013.
REQ-024 SHALL ignore write data presented in W_IDLE: no RAM write and no beat counted.
REQ-025 SHALL run the read and write FSMs concurrently and independently.
REQ-026 SHALL, when a read issue and a write hit the same index in the same cycle, return the old data (read-first).
REQ-027 SHALL use 32-bit remaining-beat counters; len=32'hFFFFFFFF is legal and never wraps early.
REQ-028 SHALL drive rd_busy = (state != R_IDLE) || xcel_read_data_valid, and wr_busy = (state != W_IDLE).

Reset
REQ-029 SHALL, on rst=1 at a clock edge: both FSMs to IDLE; xcel_read_data_valid=0; xcel_write_data_ready=0; both request_ready outputs =1 from the first cycle after rst deasserts; xcel_read_data=0; rd_busy=wr_busy=0.
REQ-030 SHALL, on reset mid-burst, abort the burst without further RAM writes; RAM contents are not cleared.

Verification
REQ-031 SHALL pass: write addr 0x100, len 3, INCR, data 0xA0..0xA3 -> RAM words 0x40..0x43 hold 0xA0..0xA3; write_request_ready returns to 1 after the 4th beat.
REQ-032 SHALL pass: read addr 0x100, len 3, data_ready held 1 -> 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles, first valid 2 cycles after the handshake.
REQ-033 SHALL pass: same read with data_ready toggled 1,0,0,1,… -> each beat held during stall; exactly 4 distinct beats in order.
REQ-034 SHALL pass: FIXED read addr 0x104, len 2 -> RAM[0x41] returned 3 times; write addr 0x3FFC (MEM_AWIDTH=12), len 1 -> words 0xFFF then 0x000 written.
REQ-035 SHALL pass: concurrent write burst and read burst to disjoint regions -> both complete with correct data; same-index collision returns the old value.
REQ-036 SHALL pass: rst asserted after 2 of 4 write beats -> wr_busy=0, remaining beats not written, earlier 2 words retained.
